// File: rtl/blc_cal_sched.sv
// blc_cal_sched: black-level calibration scheduler.
// Averages dark means, then rounds, clamps and slew-limits the level it publishes.
module blc_cal_sched #(
  parameter int PX_WIDTH         = 10,
  parameter int INIT_BLACK_LEVEL = 16,
  parameter int MAX_BLACK_LEVEL  = 64,
  parameter int AVG_LOG2         = 2,
  parameter int SETTLE_W         = 4,
  parameter int PERIOD_W         = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                sof_i,
  input  logic                mean_valid_i,
  input  logic [PX_WIDTH-1:0] mean_i,
  input  logic                cal_req_i,
  input  logic                auto_en_i,
  input  logic [PERIOD_W-1:0] auto_period_i,
  input  logic [SETTLE_W-1:0] settle_frames_i,
  input  logic [PX_WIDTH-1:0] max_step_i,
  output logic [PX_WIDTH-1:0] bl_o,
  output logic                bl_stb_o,
  output logic                busy_o,
  output logic                clamp_o,
  output logic                timeout_o
);

  localparam int ACC_W  = PX_WIDTH + AVG_LOG2;
  localparam int SMP_W  = AVG_LOG2 + 1;
  localparam int N_AVG  = 1 << AVG_LOG2;
  localparam int TO_FRM = N_AVG + 2;
  localparam int HALF   = (AVG_LOG2 == 0) ? 0 : (1 << (AVG_LOG2 - 1));
  localparam int FRM_W  = (SETTLE_W > 5) ? SETTLE_W : 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_CALC,
    S_APPLY
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] auto_q, auto_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic [SMP_W-1:0]    smp_q, smp_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PX_WIDTH-1:0] res_q, res_d;
  logic                flg_q, flg_d;
  logic [PX_WIDTH-1:0] bl_q, bl_d;
  logic                stb_q, stb_d;
  logic                clamp_q, clamp_d;
  logic                to_q, to_d;

  logic [ACC_W:0]      rnd;
  logic [ACC_W:0]      avg_w;
  logic [PX_WIDTH:0]   avg_c;
  logic [PX_WIDTH:0]   bl_x;
  logic [PX_WIDTH:0]   step_x;
  logic [PX_WIDTH:0]   dif;
  logic                up;
  logic                clamped;
  logic                slewed;
  logic [PX_WIDTH-1:0] calc_res;

  // Round, clamp and slew-limit the accumulated average against bl_o.
  always_comb begin
    rnd     = {1'b0, acc_q} + (ACC_W + 1)'(HALF);
    avg_w   = rnd >> AVG_LOG2;
    clamped = avg_w > (ACC_W + 1)'(MAX_BLACK_LEVEL);
    avg_c   = clamped ? (PX_WIDTH + 1)'(MAX_BLACK_LEVEL)
                      : avg_w[PX_WIDTH:0];
    bl_x    = {1'b0, bl_q};
    step_x  = {1'b0, max_step_i};
    up      = avg_c >= bl_x;
    dif     = up ? (avg_c - bl_x) : (bl_x - avg_c);
    slewed  = (max_step_i != '0) && (dif > step_x);
    if (slewed) begin
      calc_res = up ? (bl_q + max_step_i) : (bl_q - max_step_i);
    end else begin
      calc_res = avg_c[PX_WIDTH-1:0];
    end
  end

  logic                trig;
  logic                done;
  logic [PERIOD_W-1:0] auto_inc;
  logic [FRM_W-1:0]    frm_inc;
  logic [SMP_W-1:0]    smp_inc;

  // Next-state logic: trigger, settle, accumulate, compute, publish.
  always_comb begin
    state_d  = state_q;
    auto_d   = auto_q;
    frm_d    = frm_q;
    smp_d    = smp_q;
    acc_d    = acc_q;
    res_d    = res_q;
    flg_d    = flg_q;
    bl_d     = bl_q;
    clamp_d  = clamp_q;
    stb_d    = 1'b0;
    to_d     = 1'b0;
    trig     = 1'b0;
    done     = 1'b0;
    auto_inc = auto_q + 1'b1;
    frm_inc  = frm_q + 1'b1;
    smp_inc  = smp_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!auto_en_i) begin
          auto_d = '0;
        end else if (sof_i && auto_period_i != '0) begin
          auto_d = auto_inc;
          trig   = auto_inc >= auto_period_i;
        end
        if (cal_req_i) trig = 1'b1;
        if (trig) begin
          auto_d  = '0;
          frm_d   = '0;
          smp_d   = '0;
          acc_d   = '0;
          state_d = (settle_frames_i == '0) ? S_ACCUM : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (sof_i) begin
          frm_d = frm_inc;
          if (frm_inc >= FRM_W'(settle_frames_i)) begin
            frm_d   = '0;
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (mean_valid_i) begin
          acc_d = acc_q + ACC_W'(mean_i);
          smp_d = smp_inc;
          done  = smp_inc == SMP_W'(N_AVG);
          if (done) state_d = S_CALC;
        end
        if (sof_i) begin
          frm_d = frm_inc;
          if (!done && frm_inc >= FRM_W'(TO_FRM)) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_CALC: begin
        res_d   = calc_res;
        flg_d   = clamped | slewed;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        bl_d    = res_q;
        clamp_d = flg_q;
        stb_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      auto_q  <= '0;
      frm_q   <= '0;
      smp_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flg_q   <= 1'b0;
      bl_q    <= PX_WIDTH'(INIT_BLACK_LEVEL);
      stb_q   <= 1'b0;
      clamp_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      frm_q   <= frm_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      bl_q    <= bl_d;
      stb_q   <= stb_d;
      clamp_q <= clamp_d;
      to_q    <= to_d;
    end
  end

  assign bl_o      = bl_q;
  assign bl_stb_o  = stb_q;
  assign busy_o    = state_q != S_IDLE;
  assign clamp_o   = clamp_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_blc_cal_sched.sv
// tb_blc_cal_sched: scoreboard bench for blc_cal_sched.
// Expected publish/timeout events are queued by stimulus, popped by a monitor.
module tb_blc_cal_sched;

  localparam int NAVG  = 4;
  localparam int MAXBL = 64;
  localparam int INIT  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sof = 1'b0;
  logic       mv = 1'b0;
  logic       req = 1'b0;
  logic       aen = 1'b0;
  logic [9:0] mean = '0;
  logic [9:0] step = '0;
  logic [7:0] per = '0;
  logic [3:0] settle = '0;
  logic [9:0] bl;
  logic       stb, busy, clp, to;

  always #5 clk = ~clk;

  blc_cal_sched dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .sof_i           (sof),
    .mean_valid_i    (mv),
    .mean_i          (mean),
    .cal_req_i       (req),
    .auto_en_i       (aen),
    .auto_period_i   (per),
    .settle_frames_i (settle),
    .max_step_i      (step),
    .bl_o            (bl),
    .bl_stb_o        (stb),
    .busy_o          (busy),
    .clamp_o         (clp),
    .timeout_o       (to)
  );

  typedef struct {
    int is_to;
    int bl;
    int clp;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  m_bl = INIT;
  int  m_clp = 0;
  int  ms[4];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every publish or timeout must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (stb || to)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event stb=%0d to=%0d bl=%0d", stb, to, bl);
      end else begin
        mon_e = q.pop_front();
        chk("ev_kind", int'(to), mon_e.is_to);
        chk("ev_stb", int'(stb), 1 - mon_e.is_to);
        chk("ev_bl", int'(bl), mon_e.bl);
        chk("ev_clamp", int'(clp), mon_e.clp);
      end
    end
  end

  // Reference: average, round half up, clamp, then limit the step from m_bl.
  function automatic void model(input int sum, input int stp,
                                output int res, output int c);
    int avg, cl, d;
    bit sl;
    avg = (sum + NAVG / 2) / NAVG;
    cl  = (avg > MAXBL) ? MAXBL : avg;
    d   = (cl > m_bl) ? cl - m_bl : m_bl - cl;
    res = cl;
    sl  = 0;
    if (stp != 0 && d > stp) begin
      sl  = 1;
      res = (cl > m_bl) ? m_bl + stp : m_bl - stp;
    end
    c = (avg > MAXBL || sl) ? 1 : 0;
  endfunction

  task automatic trig();
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("busy_after_trig", int'(busy), 1);
  endtask

  task automatic settle_phase(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        mv   = 1'b1;
        mean = 10'($urandom_range(0, 1023));
        tick();
        mv   = 1'b0;
      end
      sof = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        mv   = 1'b1;
        mean = 10'($urandom_range(0, 1023));
      end
      tick();
      sof = 1'b0;
      mv  = 1'b0;
    end
  endtask

  task automatic accum(input int m[4], input int budget);
    int sum, res, c, bud;
    ev_t e;
    sum = 0;
    bud = budget;
    foreach (m[i]) sum += m[i];
    model(sum, int'(step), res, c);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if (bud > 0 && $urandom_range(0, 2) == 0) begin
          sof = 1'b1;
          bud--;
        end
        tick();
        sof = 1'b0;
      end
      if (bud > 0 && $urandom_range(0, 2) == 0) begin
        sof = 1'b1;
        bud--;
      end
      mv   = 1'b1;
      mean = 10'(m[i]);
      if (i == 3) begin
        e.is_to = 0;
        e.bl    = res;
        e.clp   = c;
        q.push_back(e);
      end
      tick();
      mv  = 1'b0;
      sof = 1'b0;
    end
    tick();
    chk("lat_stb_early", int'(stb), 0);
    tick();
    chk("lat_stb", int'(stb), 1);
    chk("lat_bl", int'(bl), res);
    chk("idle_after_apply", int'(busy), 0);
    m_bl  = res;
    m_clp = c;
    tick();
  endtask

  task automatic rand_means(input int wide);
    for (int i = 0; i < 4; i++)
      ms[i] = wide ? $urandom_range(0, 1023) : $urandom_range(0, 90);
  endtask

  initial begin
    ev_t e;
    repeat (2) tick();
    chk("rst_bl", int'(bl), INIT);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stb", int'(stb), 0);
    chk("rst_clamp", int'(clp), 0);
    chk("rst_to", int'(to), 0);
    rst_n = 1'b1;
    tick();

    settle = 4'd1;
    step   = '0;
    trig();
    settle_phase(1);
    ms = '{20, 21, 21, 22};
    accum(ms, 0);

    settle = 4'd0;
    trig();
    ms = '{100, 100, 100, 100};
    accum(ms, 0);

    rst_n = 1'b0;
    #1;
    chk("rst2_bl", int'(bl), INIT);
    tick();
    rst_n = 1'b1;
    m_bl  = INIT;
    m_clp = 0;
    step  = 10'd4;
    trig();
    ms = '{30, 30, 30, 30};
    accum(ms, 0);

    settle = 4'd2;
    trig();
    settle_phase(2);
    for (int k = 0; k < 5; k++) begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      chk("no_early_timeout", int'(busy), 1);
    end
    rand_means(0);
    accum(ms, 0);

    settle = 4'd0;
    trig();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        e.is_to = 1;
        e.bl    = m_bl;
        e.clp   = m_clp;
        q.push_back(e);
      end
      sof = 1'b1;
      tick();
      sof = 1'b0;
      chk("timeout_busy", int'(busy), (k == 5) ? 0 : 1);
    end
    chk("timeout_pulse", int'(to), 1);
    tick();

    step = '0;
    aen  = 1'b1;
    per  = 8'd3;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("auto_busy", int'(busy), (k == 2) ? 1 : 0);
      end
      req = 1'b1;
      tick();
      req = 1'b0;
      rand_means(0);
      accum(ms, 0);
    end
    per = 8'd0;
    for (int k = 0; k < 5; k++) begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      chk("period0_idle", int'(busy), 0);
    end
    aen = 1'b0;

    trig();
    for (int k = 0; k < 2; k++) begin
      mv   = 1'b1;
      mean = 10'd200;
      tick();
      mv   = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_bl", int'(bl), INIT);
    chk("midrst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    m_bl  = INIT;
    m_clp = 0;
    for (int k = 0; k < 4; k++) begin
      mv   = 1'b1;
      mean = 10'd50;
      tick();
      mv   = 1'b0;
    end
    repeat (3) tick();
    chk("midrst_quiet_bl", int'(bl), INIT);

    for (int it = 0; it < 25; it++) begin
      settle = 4'($urandom_range(0, 3));
      step   = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(1, 20)) : '0;
      trig();
      settle_phase(int'(settle));
      rand_means($urandom_range(0, 3) == 0);
      accum(ms, $urandom_range(0, 3));
    end

    repeat (5) tick();
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
